// File: rtl/store_pkg.sv
// Shared constants, queue-entry layout and drain FSM encoding
// for the store path.
package store_pkg;

    localparam logic [6:0]  OPC_STORE    = 7'b0100011;
    localparam logic [2:0]  FNC_SB       = 3'b000;
    localparam logic [2:0]  FNC_SH       = 3'b001;
    localparam logic [2:0]  FNC_SW       = 3'b010;
    localparam logic [31:0] UART_TX_ADDR = 32'h8000_0008;

    typedef enum logic {
        TGT_DMEM,
        TGT_UART
    } target_e;

    typedef struct packed {
        target_e     target;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DMEM_WR,
        ST_UART_WAIT
    } state_e;

endpackage

// File: rtl/store_fifo.sv
// Two-entry queue; push ignored when full, pop ignored when empty.
module store_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_proc.sv
// Store decode, in-order queue and DMEM/UART drain FSM.
// STORE_MISALIGN_FAULT_EN: drop misaligned SH/SW and pulse fault.
module store_proc
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        fault,
    output logic        busy
);

    entry_t dec;
    entry_t head;
    logic   st_ok;
    logic   route_ok;
    logic   accept;
    logic   push;
    logic   pop;
    logic   full;
    logic   empty;
    state_e state;
    state_e state_n;

    assign req_ready = !full;
    assign accept    = req_valid && req_ready;

    always_comb begin
        dec      = '0;
        st_ok    = 1'b0;
        route_ok = 1'b1;
        unique case (1'b1)
            (req_funct3 == FNC_SB): begin
                st_ok     = 1'b1;
                dec.we    = 4'b0001 << req_addr[1:0];
                dec.wdata = {4{req_data[7:0]}};
            end
            (req_funct3 == FNC_SH): begin
                st_ok     = 1'b1;
                dec.we    = req_addr[1] ? 4'b1100 : 4'b0011;
                dec.wdata = {2{req_data[15:0]}};
            end
            (req_funct3 == FNC_SW): begin
                st_ok     = 1'b1;
                dec.we    = 4'b1111;
                dec.wdata = req_data;
            end
            default: st_ok = 1'b0;
        endcase
        st_ok    = st_ok && (req_opcode == OPC_STORE);
        dec.addr = {req_addr[31:2], 2'b00};
        if (req_addr == UART_TX_ADDR) begin
            dec.target = TGT_UART;
        end else begin
            dec.target = TGT_DMEM;
            route_ok   = !req_addr[31];
        end
    end

`ifdef STORE_MISALIGN_FAULT_EN
    logic mis;
    logic fault_q;

    assign mis = ((req_funct3 == FNC_SH) && req_addr[0]) ||
                 ((req_funct3 == FNC_SW) && (req_addr[1:0] != 2'b00));
    assign push  = accept && st_ok && route_ok && !mis;
    assign fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= accept && st_ok && mis;
    end
`else
    assign push  = accept && st_ok && route_ok;
    assign fault = 1'b0;
`endif

    store_fifo #(
        .W($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (dec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        pop           = 1'b0;
        dmem_we       = 4'b0000;
        uart_tx_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n = (head.target == TGT_UART) ? ST_UART_WAIT : ST_DMEM_WR;
                end
            end
            ST_DMEM_WR: begin
                dmem_we = head.we;
                pop     = 1'b1;
                state_n = ST_IDLE;
            end
            ST_UART_WAIT: begin
                uart_tx_valid = 1'b1;
                if (uart_tx_ready) begin
                    pop     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Data buses always show the head so they are stable while strobed.
    assign dmem_addr    = head.addr;
    assign dmem_wdata   = head.wdata;
    assign uart_tx_data = head.wdata[7:0];
    assign busy         = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_store_proc.sv
// Directed bench for store_proc with an in-order reference queue.
module tb_store_proc;

`ifdef STORE_MISALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_tx_data;
    logic        fault;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          uart;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    bit   fault_exp = 1'b0;
    bit   m_keep;
    bit   m_flt;
    exp_t m_e;
    bit   prev_wait = 1'b0;
    logic [7:0] prev_data = '0;

    store_proc dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_data  (uart_tx_data),
        .fault         (fault),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Reference: size/offset arithmetic on the byte address.
    function automatic void ref_model(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] d,
                                      output bit keep, output bit flt, output exp_t e);
        int size;
        int off;
        keep = 1'b0;
        flt  = 1'b0;
        e    = '{uart: 1'b0, we: 4'h0, addr: 32'h0, wdata: 32'h0};
        if (op != OP_ST || f3 > 3'd2) return;
        size = 1 << f3;
        if (FAULT_EN && (a % size) != 0) begin
            flt = 1'b1;
            return;
        end
        if (a == 32'h8000_0008) begin
            e.uart  = 1'b1;
            e.wdata = {24'h0, d[7:0]};
            keep    = 1'b1;
            return;
        end
        if (a >= 32'h8000_0000) return;
        off    = ((a % 4) / size) * size;
        e.we   = 4'(((1 << size) - 1) << off);
        e.addr = a - (a % 4);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
        keep = 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fault_exp = 1'b0;
        end else begin
            fault_exp = 1'b0;
            if (req_valid && req_ready) begin
                ref_model(req_opcode, req_funct3, req_addr, req_data, m_keep, m_flt, m_e);
                fault_exp = m_flt;
                if (m_keep) q.push_back(m_e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            chk("busy", busy, (q.size() != 0));
            chk("fault", fault, fault_exp);
            if (dmem_we != 4'h0) begin
                if (q.size() == 0 || q[0].uart) begin
                    chk("dmem_unexp", dmem_we, 4'h0);
                end else begin
                    chk("dmem_we", dmem_we, q[0].we);
                    chk("dmem_addr", dmem_addr, q[0].addr);
                    chk("dmem_wdata", dmem_wdata, q[0].wdata);
                    void'(q.pop_front());
                end
            end
            if (uart_tx_valid && prev_wait) chk("uart_stable", uart_tx_data, prev_data);
            if (uart_tx_valid) begin
                if (q.size() == 0 || !q[0].uart) begin
                    chk("uart_unexp", uart_tx_valid, 1'b0);
                end else if (uart_tx_ready) begin
                    chk("uart_byte", uart_tx_data, q[0].wdata[7:0]);
                    void'(q.pop_front());
                end
            end
            prev_wait = uart_tx_valid && !uart_tx_ready;
            prev_data = uart_tx_data;
        end
    end

    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req_opcode = op;
        req_funct3 = f3;
        req_addr   = a;
        req_data   = d;
        req_valid  = 1'b1;
        while (!req_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("send_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_we(input string nm, input logic [3:0] we, input logic [31:0] a,
                           input logic [31:0] wd, input bit lat);
        bit found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dmem_we != 4'h0) begin
                chk({nm, "_we"}, dmem_we, we);
                chk({nm, "_addr"}, dmem_addr, a);
                chk({nm, "_wdata"}, dmem_wdata, wd);
                if (lat) chk({nm, "_lat"}, i, 1);
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({nm, "_none"}, dmem_we, we);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", dmem_we, 4'h0);
        chk("rst_uv", uart_tx_valid, 1'b0);
        chk("rst_fault", fault, 1'b0);
        #10 rst = 1'b0;
        idle(2);

        send(OP_ST, 3'b000, 32'h0000_0013, 32'hA5A5_A5EF);
        wait_we("sb13", 4'b1000, 32'h0000_0010, 32'hEFEF_EFEF, 1'b1);
        idle(2);
        send(OP_ST, 3'b001, 32'h0000_0022, 32'h0000_1234);
        wait_we("sh22", 4'b1100, 32'h0000_0020, 32'h1234_1234, 1'b0);
        idle(2);
        send(OP_ST, 3'b001, 32'h0000_0020, 32'h0000_BEEF);
        wait_we("sh20", 4'b0011, 32'h0000_0020, 32'hBEEF_BEEF, 1'b0);
        idle(2);
        send(OP_ST, 3'b000, 32'h0000_0041, 32'h0000_0077);
        wait_we("sb41", 4'b0010, 32'h0000_0040, 32'h7777_7777, 1'b0);
        idle(2);

        send(OP_ST, 3'b010, 32'h9000_0000, 32'h1111_1111);
        send(OP_ST, 3'b011, 32'h0000_0100, 32'h2222_2222);
        send(OP_LD, 3'b010, 32'h0000_0100, 32'h3333_3333);
        @(negedge clk);
        chk("load_busy", busy, 1'b0);
        chk("load_fault", fault, 1'b0);
        idle(2);

        send(OP_ST, 3'b010, 32'h0000_0006, 32'hDEAD_BEEF);
        if (FAULT_EN) begin
            @(negedge clk);
            chk("mis_fault", fault, 1'b1);
            @(negedge clk);
            chk("mis_fault_once", fault, 1'b0);
        end else begin
            wait_we("sw06", 4'b1111, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0);
        end
        idle(3);

        send(OP_ST, 3'b010, 32'h8000_0008, 32'h0000_0041);
        send(OP_ST, 3'b010, 32'h0000_0100, 32'hCAFE_F00D);
        chk("full_ready", req_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("uart_hold_v", uart_tx_valid, 1'b1);
            chk("uart_hold_d", uart_tx_data, 8'h41);
        end
        @(posedge clk);
        #1 uart_tx_ready = 1'b1;
        @(posedge clk);
        #1 uart_tx_ready = 1'b0;
        idle(4);

        send(OP_ST, 3'b010, 32'h0000_0200, 32'h1122_3344);
        send(OP_ST, 3'b000, 32'h0000_0203, 32'h0000_00AB);
        send(OP_ST, 3'b001, 32'h0000_0206, 32'h0000_5566);
        send(OP_ST, 3'b000, 32'h8000_0008, 32'h0000_0155);
        @(posedge clk);
        #1 uart_tx_ready = 1'b1;
        idle(8);
        uart_tx_ready = 1'b0;

        send(OP_ST, 3'b000, 32'h8000_0008, 32'h0000_005A);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_uv", uart_tx_valid, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("arst_uv", uart_tx_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", req_ready, 1'b1);
        idle(2);
        @(negedge clk);
        #1 rst = 1'b0;
        uart_tx_ready = 1'b1;
        idle(6);
        uart_tx_ready = 1'b0;

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
